// File: rtl/lsq_inorder_mp.sv
// rtl/lsq_inorder_mp.sv - in-order load/store queue with CDB wakeup and head-only issue
// Entry packing (MSB..LSB): valid, is_load, is_store, rob_entry, pd, ps1, ps1_v, ps2, ps2_v.
module lsq_inorder_mp #(
  parameter int DEPTH         = 16,
  parameter int PREG_W        = 6,
  parameter int ROB_IDX_W     = 4,
  parameter int NUM_CDB       = 2,
  parameter int BYPASS_WAKEUP = 1,
  parameter int ENTRY_W       = 5 + ROB_IDX_W + 3 * PREG_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        enq_valid_i,
  output logic                        enq_ready_o,
  input  logic [ENTRY_W-1:0]          enq_entry_i,
  input  logic [NUM_CDB-1:0]          cdb_valid_i,
  input  logic [NUM_CDB*PREG_W-1:0]   cdb_pd_i,
  input  logic [ROB_IDX_W-1:0]        rob_head_i,
  output logic                        issue_valid_o,
  input  logic                        issue_ready_i,
  output logic [ENTRY_W-1:0]          issue_entry_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        is_empty_o,
  output logic                        is_full_o
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic                 valid;
    logic                 is_load;
    logic                 is_store;
    logic [ROB_IDX_W-1:0] rob_entry;
    logic [PREG_W-1:0]    pd;
    logic [PREG_W-1:0]    ps1;
    logic                 ps1_v;
    logic [PREG_W-1:0]    ps2;
    logic                 ps2_v;
  } rename_data_t;

  rename_data_t mem_q [DEPTH];
  logic [AW:0]  head_q, head_d;
  logic [AW:0]  tail_q, tail_d;
  logic [AW:0]  count_q, count_d;

  rename_data_t head_e, issue_w, enq_in, enq_w;
  logic         r1, r2, head_rdy, kind_ok;
  logic         is_empty, is_full, issue_valid, enq_fire, deq_fire;

  // Preg 0 is the hardwired-ready register, so a broadcast of 0 never wakes anything.
  function automatic logic cdb_hit(input logic [PREG_W-1:0]         ps,
                                   input logic [NUM_CDB-1:0]        v,
                                   input logic [NUM_CDB*PREG_W-1:0] pds);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (v[p] && (pds[p*PREG_W +: PREG_W] != '0) && (pds[p*PREG_W +: PREG_W] == ps)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  always_comb begin
    is_empty = (head_q == tail_q);
    is_full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    head_e   = mem_q[head_q[AW-1:0]];

    r1 = head_e.ps1_v || ((BYPASS_WAKEUP != 0) && cdb_hit(head_e.ps1, cdb_valid_i, cdb_pd_i));
    r2 = head_e.ps2_v || ((BYPASS_WAKEUP != 0) && cdb_hit(head_e.ps2, cdb_valid_i, cdb_pd_i));
    head_rdy = !is_empty && head_e.valid && r1 && r2;
    kind_ok  = head_e.is_load || (head_e.is_store && (head_e.rob_entry == rob_head_i));
    issue_valid = head_rdy && kind_ok && !flush_i;

    issue_w       = head_e;
    issue_w.ps1_v = r1;
    issue_w.ps2_v = r2;

    enq_fire = enq_valid_i && !is_full;
    deq_fire = issue_valid && issue_ready_i;

    enq_in       = rename_data_t'(enq_entry_i);
    enq_w        = enq_in;
    enq_w.valid  = 1'b1;
    enq_w.ps1_v  = enq_in.ps1_v || cdb_hit(enq_in.ps1, cdb_valid_i, cdb_pd_i);
    enq_w.ps2_v  = enq_in.ps2_v || cdb_hit(enq_in.ps2, cdb_valid_i, cdb_pd_i);

    head_d  = deq_fire ? head_q + (AW+1)'(1) : head_q;
    tail_d  = enq_fire ? tail_q + (AW+1)'(1) : tail_q;
    count_d = count_q;
    if (enq_fire && !deq_fire) begin
      count_d = count_q + (AW+1)'(1);
    end else if (deq_fire && !enq_fire) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Flush shares the reset path: it overrides any same-cycle enqueue, dequeue or wakeup.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].valid) begin
          if (cdb_hit(mem_q[i].ps1, cdb_valid_i, cdb_pd_i)) mem_q[i].ps1_v <= 1'b1;
          if (cdb_hit(mem_q[i].ps2, cdb_valid_i, cdb_pd_i)) mem_q[i].ps2_v <= 1'b1;
        end
      end
      if (enq_fire) mem_q[tail_q[AW-1:0]] <= enq_w;
      if (deq_fire) mem_q[head_q[AW-1:0]] <= '0;
    end
  end

  assign enq_ready_o   = !is_full;
  assign issue_valid_o = issue_valid;
  assign issue_entry_o = issue_valid ? ENTRY_W'(issue_w) : '0;
  assign count_o       = count_q;
  assign is_empty_o    = is_empty;
  assign is_full_o     = is_full;

endmodule

// File: tb/tb_lsq_inorder_mp.sv
// tb/tb_lsq_inorder_mp.sv - directed and randomized bench for lsq_inorder_mp against a queue model
module tb_lsq_inorder_mp;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic       is_store;
    logic [3:0] rob;
    logic [5:0] pd;
    logic [5:0] ps1;
    logic       ps1_v;
    logic [5:0] ps2;
    logic       ps2_v;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst, flush, enq_valid, issue_ready;
  ent_t       enq_entry;
  logic [1:0] cdb_valid;
  logic [11:0] cdb_pd;
  logic [3:0] rob_head;
  logic       enq_ready, issue_valid, is_empty, is_full;
  ent_t       issue_entry;
  logic [4:0] count;

  ent_t q[$];
  logic exp_iv;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lsq_inorder_mp #(.DEPTH(DEPTH), .PREG_W(6), .ROB_IDX_W(4), .NUM_CDB(2), .BYPASS_WAKEUP(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_entry_i(enq_entry),
    .cdb_valid_i(cdb_valid), .cdb_pd_i(cdb_pd), .rob_head_i(rob_head),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready), .issue_entry_o(issue_entry),
    .count_o(count), .is_empty_o(is_empty), .is_full_o(is_full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [5:0] ps);
    logic h;
    h = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (cdb_valid[p] && cdb_pd[p*6 +: 6] != 6'd0 && cdb_pd[p*6 +: 6] == ps) h = 1'b1;
    end
    return h;
  endfunction

  function automatic ent_t mk(input int kind, input int rob, input int ps1, input int v1,
                              input int ps2, input int v2, input int pd);
    ent_t e;
    e = '0;
    e.valid    = 1'b1;
    e.is_load  = (kind == 1);
    e.is_store = (kind == 2);
    e.rob      = 4'(rob);
    e.ps1      = 6'(ps1);
    e.ps1_v    = (v1 != 0);
    e.ps2      = 6'(ps2);
    e.ps2_v    = (v2 != 0);
    e.pd       = 6'(pd);
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    int   k;
    k = $urandom_range(0, 19);
    e = '0;
    e.valid    = 1'($urandom);
    e.is_load  = (k < 11);
    e.is_store = (k >= 11 && k < 19);
    e.rob      = 4'($urandom_range(0, 3));
    e.pd       = 6'($urandom);
    e.ps1      = 6'($urandom_range(0, 7));
    e.ps1_v    = (e.ps1 == 6'd0) ? 1'b1 : 1'($urandom);
    e.ps2      = 6'($urandom_range(0, 7));
    e.ps2_v    = (e.ps2 == 6'd0) ? 1'b1 : 1'($urandom);
    return e;
  endfunction

  task automatic idle();
    rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; issue_ready = 1'b0;
    cdb_valid = '0; cdb_pd = '0;
  endtask

  task automatic settle_and_check();
    ent_t h, x;
    #1;
    exp_iv = 1'b0;
    x = '0;
    if (q.size() != 0) begin
      h = q[0];
      if ((h.ps1_v || hit(h.ps1)) && (h.ps2_v || hit(h.ps2)) && !flush &&
          (h.is_load || (h.is_store && h.rob == rob_head))) begin
        exp_iv  = 1'b1;
        x       = h;
        x.ps1_v = 1'b1;
        x.ps2_v = 1'b1;
      end
    end
    check("issue_valid", 64'(issue_valid), 64'(exp_iv));
    check("issue_entry", 64'(issue_entry), 64'(x));
    check("count", 64'(count), 64'(q.size()));
    check("is_empty", 64'(is_empty), 64'(q.size() == 0));
    check("is_full", 64'(is_full), 64'(q.size() == DEPTH));
    check("enq_ready", 64'(enq_ready), 64'(q.size() < DEPTH));
  endtask

  task automatic clock_edge();
    ent_t e;
    bit   do_enq;
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      do_enq = enq_valid && (q.size() < DEPTH);
      if (exp_iv && issue_ready) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        if (hit(e.ps1)) e.ps1_v = 1'b1;
        if (hit(e.ps2)) e.ps2_v = 1'b1;
        q[i] = e;
      end
      if (do_enq) begin
        e = enq_entry;
        e.valid = 1'b1;
        if (hit(e.ps1)) e.ps1_v = 1'b1;
        if (hit(e.ps2)) e.ps2_v = 1'b1;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    settle_and_check();
    clock_edge();
  endtask

  initial begin
    idle();
    rst = 1'b1; rob_head = '0; enq_entry = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    // fill to full with ready loads; the 17th must be dropped
    enq_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      enq_entry = mk(1, 0, 0, 1, 0, 1, i + 1);
      cycle();
    end
    enq_entry = mk(1, 0, 0, 1, 0, 1, 63);
    settle_and_check();
    check("full_count", 64'(count), 64'd16);
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    clock_edge();
    enq_valid = 1'b0; issue_ready = 1'b1;
    repeat (DEPTH) cycle();
    settle_and_check();
    check("drained_empty", 64'(is_empty), 64'd1);
    clock_edge();

    // same-cycle bypass at the head
    idle();
    enq_valid = 1'b1; enq_entry = mk(1, 0, 5, 0, 0, 1, 1);
    cycle();
    enq_valid = 1'b0;
    settle_and_check();
    check("no_wake_iv", 64'(issue_valid), 64'd0);
    clock_edge();
    cdb_valid = 2'b10; cdb_pd = {6'd5, 6'd0}; issue_ready = 1'b1;
    settle_and_check();
    check("bypass_iv", 64'(issue_valid), 64'd1);
    check("bypass_ps1v", 64'(issue_entry.ps1_v), 64'd1);
    clock_edge();

    // enqueue-cycle wakeup
    idle();
    enq_valid = 1'b1; enq_entry = mk(1, 0, 0, 1, 9, 0, 2);
    cdb_valid = 2'b01; cdb_pd = {6'd0, 6'd9};
    cycle();
    idle();
    settle_and_check();
    check("enq_wake_iv", 64'(issue_valid), 64'd1);
    check("enq_wake_ps2v", 64'(issue_entry.ps2_v), 64'd1);
    issue_ready = 1'b1;
    clock_edge();

    // store waits for ROB head and holds under backpressure
    idle();
    enq_valid = 1'b1; enq_entry = mk(2, 3, 0, 1, 0, 1, 3); rob_head = 4'd2;
    cycle();
    enq_valid = 1'b0;
    settle_and_check();
    check("store_wait_iv", 64'(issue_valid), 64'd0);
    clock_edge();
    rob_head = 4'd3;
    repeat (3) begin
      settle_and_check();
      check("store_hold_iv", 64'(issue_valid), 64'd1);
      check("store_hold_count", 64'(count), 64'd1);
      clock_edge();
    end
    issue_ready = 1'b1;
    cycle();
    settle_and_check();
    check("store_deq_count", 64'(count), 64'd0);
    clock_edge();

    // steady enqueue+dequeue at count 4 across the pointer wrap
    idle();
    enq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq_entry = mk(1, 0, 0, 1, 0, 1, 10 + i);
      cycle();
    end
    issue_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enq_entry = mk(1, 0, 0, 1, 0, 1, 20 + i);
      settle_and_check();
      check("steady_count", 64'(count), 64'd4);
      clock_edge();
    end
    enq_valid = 1'b0;
    repeat (4) cycle();

    // flush beats enqueue and issue
    idle();
    enq_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      enq_entry = mk(1, 0, 0, 1, 0, 1, 40 + i);
      cycle();
    end
    issue_ready = 1'b1; flush = 1'b1;
    settle_and_check();
    check("flush_iv", 64'(issue_valid), 64'd0);
    clock_edge();
    idle();
    settle_and_check();
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(is_empty), 64'd1);
    clock_edge();

    // randomized traffic with alternating backpressure
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 500; c++) begin
        enq_valid   = ($urandom_range(0, 99) < 60);
        enq_entry   = rand_ent();
        cdb_valid   = 2'($urandom);
        cdb_pd      = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
        rob_head    = 4'($urandom_range(0, 3));
        issue_ready = ($urandom_range(0, 99) < ((blk % 2 == 0) ? 15 : 80));
        flush       = ($urandom_range(0, 99) < 2);
        cycle();
      end
    end

    // reset mid-operation
    rst = 1'b1; flush = 1'b0;
    cycle();
    idle();
    settle_and_check();
    check("rst_mid_empty", 64'(is_empty), 64'd1);
    clock_edge();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
